// File: rtl/exe_stage_if.sv
// exe_stage_if: decode, memory-stage and ALU signals of the execute stage
interface exe_stage_if;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [31:0] ds_pc;
  logic [18:0] ds_alu_op;
  logic [31:0] ds_alu_src1;
  logic [31:0] ds_alu_src2;
  logic [4:0]  ds_dest;
  logic        ds_gr_we;
  logic [18:0] alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic        alu_div_done;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_fwd_we;
  logic [4:0]  es_fwd_dest;
  logic        es_fwd_ready;
  modport slave (
    input  ds_to_es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2, ds_dest, ds_gr_we,
    input  alu_result, alu_div_done, ms_allowin,
    output es_allowin, alu_op, alu_src1, alu_src2, es_to_ms_valid,
    output es_pc, es_result, es_dest, es_gr_we, es_fwd_we, es_fwd_dest, es_fwd_ready
  );
  modport master (
    output ds_to_es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2, ds_dest, ds_gr_we,
    output alu_result, alu_div_done, ms_allowin,
    input  es_allowin, alu_op, alu_src1, alu_src2, es_to_ms_valid,
    input  es_pc, es_result, es_dest, es_gr_we, es_fwd_we, es_fwd_dest, es_fwd_ready
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: LoongArch32 execute stage with divider wait/hold and decode bypass
module exe_stage #(
  parameter int DIV_LATENCY = 36
) (
  input logic       clk,
  input logic       reset,
  exe_stage_if.slave bus
);
  localparam int CW = $clog2(DIV_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(DIV_LATENCY);
  typedef enum logic [1:0] {IDLE, DIV_WAIT, DIV_HOLD} state_t;
  state_t        state_q, state_d;
  logic          es_valid_q, es_valid_d;
  logic [31:0]   pc_q, pc_d;
  logic [18:0]   op_q, op_d;
  logic [31:0]   src1_q, src1_d;
  logic [31:0]   src2_q, src2_d;
  logic [4:0]    dest_q, dest_d;
  logic          gr_we_q, gr_we_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   div_buf_q, div_buf_d;
  logic          hold, is_div, div_complete, es_ready_go, es_allowin, load;
  // handshake, divider completion and next-state for stage fields and FSM
  always_comb begin
    hold         = (state_q == DIV_HOLD);
    is_div       = es_valid_q & (|op_q[18:15]);
    div_complete = (state_q == DIV_WAIT) & bus.alu_div_done & (wait_cnt_q >= LAT);
    es_ready_go  = ~is_div | div_complete | hold;
    es_allowin   = ~es_valid_q | (es_ready_go & bus.ms_allowin);
    load         = bus.ds_to_es_valid & es_allowin;
    es_valid_d   = es_allowin ? bus.ds_to_es_valid : es_valid_q;
    pc_d         = load ? bus.ds_pc : pc_q;
    op_d         = load ? bus.ds_alu_op : op_q;
    src1_d       = load ? bus.ds_alu_src1 : src1_q;
    src2_d       = load ? bus.ds_alu_src2 : src2_q;
    dest_d       = load ? bus.ds_dest : dest_q;
    gr_we_d      = load ? bus.ds_gr_we : gr_we_q;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    div_buf_d    = div_buf_q;
    if (es_allowin) begin
      state_d    = (load & (|bus.ds_alu_op[18:15])) ? DIV_WAIT : IDLE;
      wait_cnt_d = '0;
    end else if (state_q == DIV_WAIT) begin
      state_d    = div_complete ? DIV_HOLD : DIV_WAIT;
      div_buf_d  = div_complete ? bus.alu_result : div_buf_q;
      wait_cnt_d = (wait_cnt_q == LAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end
  // stage and FSM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      es_valid_q <= 1'b0;
      pc_q       <= '0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      dest_q     <= '0;
      gr_we_q    <= 1'b0;
      wait_cnt_q <= '0;
      div_buf_q  <= '0;
    end else begin
      state_q    <= state_d;
      es_valid_q <= es_valid_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dest_q     <= dest_d;
      gr_we_q    <= gr_we_d;
      wait_cnt_q <= wait_cnt_d;
      div_buf_q  <= div_buf_d;
    end
  end
  assign bus.es_allowin     = es_allowin;
  assign bus.es_to_ms_valid = es_valid_q & es_ready_go;
  assign bus.alu_op         = es_valid_q ? (hold ? {4'b0, op_q[14:0]} : op_q) : '0;
  assign bus.alu_src1       = src1_q;
  assign bus.alu_src2       = src2_q;
  assign bus.es_pc          = pc_q;
  assign bus.es_result      = hold ? div_buf_q : bus.alu_result;
  assign bus.es_dest        = dest_q;
  assign bus.es_gr_we       = gr_we_q;
  assign bus.es_fwd_we      = es_valid_q & gr_we_q & (dest_q != 5'd0);
  assign bus.es_fwd_dest    = dest_q;
  assign bus.es_fwd_ready   = es_ready_go;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: table-driven and directed checks of the execute stage
module tb_exe_stage;
  localparam logic [18:0] ADD = 19'h00001;
  localparam logic [18:0] DIV = 19'h08000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ovr = 1'b0;
  logic [31:0] val = '0;
  int n_cmp = 0;
  int n_bad = 0;
  exe_stage_if bus();
  exe_stage #(.DIV_LATENCY(36)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always_comb bus.alu_result = ovr ? val : (bus.alu_op[0] ? bus.alu_src1 + bus.alu_src2 : 32'h0);
  typedef struct {
    logic v; logic [18:0] op; logic [31:0] s1, s2; logic [4:0] dest; logic we; logic msa;
    logic e_allow, e_tms; logic [31:0] e_res; logic [4:0] e_dest; logic e_fwe;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] dest, input logic we, input logic msa);
    bus.ds_to_es_valid = v;
    bus.ds_alu_op = op;
    bus.ds_alu_src1 = s1;
    bus.ds_alu_src2 = s2;
    bus.ds_dest = dest;
    bus.ds_gr_we = we;
    bus.ms_allowin = msa;
  endtask
  task automatic load_div;
    drive(1'b1, DIV, 32'd100, 32'd7, 5'd7, 1'b1, 1'b1);
    bus.ds_pc = 32'h2000;
    tick;
    bus.ds_to_es_valid = 1'b0;
  endtask
  task automatic div_wait(input int n, input int stray);
    for (int c = 0; c < n; c++) begin
      bus.alu_div_done = (c == stray);
      ovr = (c == stray);
      val = 32'hDEAD;
      #2;
      chk("div_allowin", bus.es_allowin, 1'b0);
      chk("div_to_ms", bus.es_to_ms_valid, 1'b0);
      chk("div_fwd_ready", bus.es_fwd_ready, 1'b0);
      if (c == 0) begin
        chk("div_alu_op", bus.alu_op, DIV);
        chk("div_alu_src1", bus.alu_src1, 32'd100);
        chk("div_alu_src2", bus.alu_src2, 32'd7);
      end
      tick;
      bus.alu_div_done = 1'b0;
      ovr = 1'b0;
    end
  endtask
  initial begin
    tbl[0] = '{1'b1, ADD, 32'd5,   32'd7,   5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  5'd0, 1'b0};
    tbl[1] = '{1'b1, ADD, 32'd1,   32'd2,   5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 32'd12, 5'd3, 1'b1};
    tbl[2] = '{1'b1, ADD, 32'd10,  32'd20,  5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3,  5'd4, 1'b1};
    tbl[3] = '{1'b1, ADD, 32'd8,   32'd9,   5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd30, 5'd5, 1'b0};
    tbl[4] = '{1'b0, ADD, 32'd0,   32'd0,   5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd17, 5'd0, 1'b0};
    tbl[5] = '{1'b1, ADD, 32'd100, 32'd100, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 32'd17, 5'd0, 1'b0};
    tbl[6] = '{1'b1, ADD, 32'd100, 32'd100, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 32'd17, 5'd0, 1'b0};
    tbl[7] = '{1'b0, '0,  32'd0,   32'd0,   5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd17, 5'd0, 1'b0};
    tbl[8] = '{1'b0, '0,  32'd0,   32'd0,   5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  5'd0, 1'b0};
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    bus.ds_pc = 32'h1000;
    bus.alu_div_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("rst_allowin", bus.es_allowin, 1'b1);
    chk("rst_to_ms", bus.es_to_ms_valid, 1'b0);
    chk("rst_alu_op", bus.alu_op, 19'h0);
    chk("rst_fwd_we", bus.es_fwd_we, 1'b0);
    chk("rst_pc", bus.es_pc, 32'h0);
    chk("rst_dest", bus.es_dest, 5'd0);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].dest, tbl[i].we, tbl[i].msa);
      #2;
      chk($sformatf("vec%0d_allowin", i), bus.es_allowin, tbl[i].e_allow);
      chk($sformatf("vec%0d_to_ms", i), bus.es_to_ms_valid, tbl[i].e_tms);
      chk($sformatf("vec%0d_result", i), bus.es_result, tbl[i].e_res);
      chk($sformatf("vec%0d_dest", i), bus.es_dest, tbl[i].e_dest);
      chk($sformatf("vec%0d_fwd_dest", i), bus.es_fwd_dest, tbl[i].e_dest);
      chk($sformatf("vec%0d_fwd_we", i), bus.es_fwd_we, tbl[i].e_fwe);
      chk($sformatf("vec%0d_fwd_ready", i), bus.es_fwd_ready, 1'b1);
      tick;
    end
    load_div;
    div_wait(36, -1);
    bus.alu_div_done = 1'b1;
    ovr = 1'b1;
    val = 32'd14;
    drive(1'b1, ADD, 32'd1, 32'd1, 5'd8, 1'b1, 1'b1);
    #2;
    chk("div_done_to_ms", bus.es_to_ms_valid, 1'b1);
    chk("div_done_result", bus.es_result, 32'd14);
    chk("div_done_allowin", bus.es_allowin, 1'b1);
    chk("div_done_pc", bus.es_pc, 32'h2000);
    chk("div_done_dest", bus.es_dest, 5'd7);
    tick;
    bus.alu_div_done = 1'b0;
    ovr = 1'b0;
    bus.ds_to_es_valid = 1'b0;
    #2;
    chk("post_div_add_to_ms", bus.es_to_ms_valid, 1'b1);
    chk("post_div_add_result", bus.es_result, 32'd2);
    chk("post_div_add_dest", bus.es_dest, 5'd8);
    tick;
    load_div;
    div_wait(36, 10);
    bus.alu_div_done = 1'b1;
    ovr = 1'b1;
    val = 32'd14;
    #2;
    chk("stray_to_ms", bus.es_to_ms_valid, 1'b1);
    chk("stray_result", bus.es_result, 32'd14);
    tick;
    bus.alu_div_done = 1'b0;
    ovr = 1'b0;
    #2;
    chk("stray_empty_to_ms", bus.es_to_ms_valid, 1'b0);
    chk("stray_empty_allowin", bus.es_allowin, 1'b1);
    tick;
    load_div;
    div_wait(36, -1);
    bus.ms_allowin = 1'b0;
    bus.alu_div_done = 1'b1;
    ovr = 1'b1;
    val = 32'd14;
    #2;
    chk("hold_in_to_ms", bus.es_to_ms_valid, 1'b1);
    chk("hold_in_result", bus.es_result, 32'd14);
    chk("hold_in_allowin", bus.es_allowin, 1'b0);
    tick;
    val = 32'hFFFF;
    #2;
    chk("hold_alu_op", bus.alu_op, 19'h0);
    chk("hold_result", bus.es_result, 32'd14);
    chk("hold_to_ms", bus.es_to_ms_valid, 1'b1);
    chk("hold_allowin", bus.es_allowin, 1'b0);
    tick;
    bus.alu_div_done = 1'b0;
    #2;
    chk("hold2_result", bus.es_result, 32'd14);
    tick;
    bus.ms_allowin = 1'b1;
    #2;
    chk("hold_ret_to_ms", bus.es_to_ms_valid, 1'b1);
    chk("hold_ret_result", bus.es_result, 32'd14);
    chk("hold_ret_allowin", bus.es_allowin, 1'b1);
    tick;
    ovr = 1'b0;
    #2;
    chk("hold_after_to_ms", bus.es_to_ms_valid, 1'b0);
    tick;
    load_div;
    div_wait(20, -1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #2;
    chk("mid_rst_allowin", bus.es_allowin, 1'b1);
    chk("mid_rst_to_ms", bus.es_to_ms_valid, 1'b0);
    chk("mid_rst_alu_op", bus.alu_op, 19'h0);
    drive(1'b1, ADD, 32'd1, 32'd1, 5'd9, 1'b1, 1'b1);
    tick;
    bus.ds_to_es_valid = 1'b0;
    bus.alu_div_done = 1'b1;
    #2;
    chk("rst_add_to_ms", bus.es_to_ms_valid, 1'b1);
    chk("rst_add_result", bus.es_result, 32'd2);
    chk("rst_add_fwd_we", bus.es_fwd_we, 1'b1);
    tick;
    bus.alu_div_done = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
